// File: rtl/priority_encoder_4to2.sv
// Registered MSB-first priority encoder; idle input holds the last index.
// Optional PRIENC_ONEHOT_EN adds a registered one-hot grant output.
module priority_encoder_4to2 #(
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [WIDTH-1:0]         in,
  output logic [$clog2(WIDTH)-1:0] out,
`ifdef PRIENC_ONEHOT_EN
  output logic [WIDTH-1:0]         grant,
`endif
  output logic                     valid
);

  localparam int OUT_W = $clog2(WIDTH);

  logic [OUT_W-1:0] w_idx;
  logic             w_any;
  logic [OUT_W-1:0] r_out;
  logic             r_valid;

  // scan from MSB down; the first set bit wins
  always_comb begin
    w_idx = '0;
    w_any = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (!w_any && in[i]) begin
        w_idx = OUT_W'(i);
        w_any = 1'b1;
      end
    end
  end

  // index register holds across idle cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_any;
      if (w_any) begin
        r_out <= w_idx;
      end
    end
  end

  assign out   = r_out;
  assign valid = r_valid;

`ifdef PRIENC_ONEHOT_EN
  logic [WIDTH-1:0] w_grant;
  logic [WIDTH-1:0] r_grant;

  // one-hot of the winner, all-zero when idle
  always_comb begin
    w_grant = '0;
    if (w_any) begin
      w_grant[w_idx] = 1'b1;
    end
  end

  // grant register clears on idle and reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant <= '0;
    end else begin
      r_grant <= w_grant;
    end
  end

  assign grant = r_grant;
`endif

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Directed bench for priority_encoder_4to2 (4-bit and 8-bit instances).
// Grant checks are compiled in only with PRIENC_ONEHOT_EN.
module tb_priority_encoder_4to2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in4 = 4'b1010;
  logic [1:0] out4;
  logic       valid4;
  logic [7:0] in8 = 8'h00;
  logic [2:0] out8;
  logic       valid8;
`ifdef PRIENC_ONEHOT_EN
  logic [3:0] grant4;
  logic [7:0] grant8;
`endif

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  priority_encoder_4to2 #(.WIDTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in4),
    .out   (out4),
`ifdef PRIENC_ONEHOT_EN
    .grant (grant4),
`endif
    .valid (valid4)
  );

  priority_encoder_4to2 #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in8),
    .out   (out8),
`ifdef PRIENC_ONEHOT_EN
    .grant (grant8),
`endif
    .valid (valid8)
  );

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // drive at negedge, sample 1 ns after the following posedge
  task automatic step(input logic [3:0] v);
    @(negedge clk);
    in4 = v;
    @(posedge clk);
    #1;
  endtask

  logic [1:0] exp_tbl [1:15];

  initial begin
    exp_tbl[1]  = 2'd0;
    exp_tbl[2]  = 2'd1;
    exp_tbl[3]  = 2'd1;
    exp_tbl[4]  = 2'd2;
    exp_tbl[5]  = 2'd2;
    exp_tbl[6]  = 2'd2;
    exp_tbl[7]  = 2'd2;
    for (int k = 8; k <= 15; k++) exp_tbl[k] = 2'd3;

    // 1: reset with 1010 applied
    #2;
    check("rst_out", 32'(out4), 0);
    check("rst_valid", 32'(valid4), 0);
    @(posedge clk);
    #1;
    check("rst_hold_out", 32'(out4), 0);
    check("rst_hold_valid", 32'(valid4), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_out", 32'(out4), 3);
    check("post_rst_valid", 32'(valid4), 1);

    // 2: sweep
    for (int k = 1; k <= 15; k++) begin
      step(4'(k));
      check($sformatf("sweep_out_%0d", k), 32'(out4), 32'(exp_tbl[k]));
      check($sformatf("sweep_valid_%0d", k), 32'(valid4), 1);
    end

    // 3: hold behaviour
    step(4'b1111);
    step(4'b0000);
    check("hold3_out", 32'(out4), 3);
    check("hold3_valid", 32'(valid4), 0);
    step(4'b0111);
    check("enc2_out", 32'(out4), 2);
    check("enc2_valid", 32'(valid4), 1);
    step(4'b0000);
    check("hold2_out", 32'(out4), 2);
    check("hold2_valid", 32'(valid4), 0);
    step(4'b0000);
    check("hold2b_out", 32'(out4), 2);

    // 5: async reset between edges while out=2
    step(4'b0100);
    check("pre_arst_out", 32'(out4), 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", 32'(out4), 0);
    check("arst_valid", 32'(valid4), 0);

    // 4: all-zero input straight out of reset
    in4 = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(4'b0000);
      check($sformatf("idle_out_%0d", k), 32'(out4), 0);
      check($sformatf("idle_valid_%0d", k), 32'(valid4), 0);
    end
    step(4'b0010);
    check("first_enc_out", 32'(out4), 1);
    check("first_enc_valid", 32'(valid4), 1);

`ifdef PRIENC_ONEHOT_EN
    // 6: one-hot grant
    step(4'b0110);
    check("grant_0110", 32'(grant4), 32'h4);
    step(4'b1001);
    check("grant_1001", 32'(grant4), 32'h8);
    step(4'b0000);
    check("grant_idle", 32'(grant4), 0);
`endif

    // 6: 8-bit instance
    @(negedge clk);
    in8 = 8'h41;
    @(posedge clk);
    #1;
    check("w8_41_out", 32'(out8), 6);
    check("w8_41_valid", 32'(valid8), 1);
`ifdef PRIENC_ONEHOT_EN
    check("w8_41_grant", 32'(grant8), 32'h40);
`endif
    @(negedge clk);
    in8 = 8'h83;
    @(posedge clk);
    #1;
    check("w8_83_out", 32'(out8), 7);
    @(negedge clk);
    in8 = 8'h00;
    @(posedge clk);
    #1;
    check("w8_idle_out", 32'(out8), 7);
    check("w8_idle_valid", 32'(valid8), 0);
    @(negedge clk);
    in8 = 8'h05;
    @(posedge clk);
    #1;
    check("w8_05_out", 32'(out8), 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
